alarm_bank: RTL and testbench

Multi-channel alarm controller. It holds NUM_ALARMS independently programmable alarm times, compares each against the running clock once per second, and rings on a match. Each channel supports auto-timeout, snooze with a bounded snooze count, and a stop request. It sits beside the timekeeping counter; its outputs drive the buzzer/LED logic.

---
 rtl/alarm_bank_if.sv | 51 +++++
 rtl/alarm_bank.sv | 191 +++++++++++++++++++
 tb/tb_alarm_bank.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_bank_if.sv
// Bus bundle for alarm_bank: timekeeping inputs, configuration write port,
// user buttons (snooze/stop) and the ringing outputs.
//
// Handshake: there is no valid/ready flow control here. sec_tick, cfg_we,
// snooze and stop are single-cycle strobes. They are acted on at the rising
// clk edge on which they are high, and they can never be stalled or refused.
// The data fields (curr_*, cfg_*) only need to be valid while their strobe is
// high. The outputs are registered and stay valid on every cycle.
interface alarm_bank_if #(
    parameter int NUM_ALARMS = 4
);
    localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    // timekeeping side
    logic                    sec_tick;
    logic [4:0]              curr_hour;
    logic [5:0]              curr_min;
    logic [5:0]              curr_sec;
    // configuration write port
    logic                    cfg_we;
    logic [IDX_W-1:0]        cfg_idx;
    logic [4:0]              cfg_hour;
    logic [5:0]              cfg_min;
    logic [5:0]              cfg_sec;
    logic                    cfg_en;
    // user buttons
    logic                    snooze;
    logic                    stop;
    // alarm outputs
    logic [NUM_ALARMS-1:0]   ring_vec;
    logic                    alarm_out;
    logic [IDX_W-1:0]        active_idx;
    // per-channel FSM state, 2 bits per channel, for debug and checkers
    logic [2*NUM_ALARMS-1:0] state_dbg;

    // driver side (timekeeper, CPU, buttons)
    modport master (
        output sec_tick, curr_hour, curr_min, curr_sec,
        output cfg_we, cfg_idx, cfg_hour, cfg_min, cfg_sec, cfg_en,
        output snooze, stop,
        input  ring_vec, alarm_out, active_idx, state_dbg
    );

    // alarm_bank side
    modport slave (
        input  sec_tick, curr_hour, curr_min, curr_sec,
        input  cfg_we, cfg_idx, cfg_hour, cfg_min, cfg_sec, cfg_en,
        input  snooze, stop,
        output ring_vec, alarm_out, active_idx, state_dbg
    );
endinterface

// File: rtl/alarm_bank.sv
// Multi-channel alarm controller. Each channel stores an alarm time and an
// enable bit. Once per second it compares the stored time against the running
// clock and rings on a match. While ringing, a channel times out by itself,
// can be snoozed a bounded number of times, and can be stopped.
module alarm_bank #(
    parameter int NUM_ALARMS  = 4,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input logic         clk,
    input logic         reset,
    alarm_bank_if.slave bus
);
    localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int SU_W  = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [7:0]      RING_LAST = 8'(RING_SECS);
    localparam logic [11:0]     SNZ_LAST  = 12'(SNOOZE_SECS);
    localparam logic [SU_W-1:0] SNZ_MAX   = SU_W'(MAX_SNOOZE);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RINGING = 2'd1;
    localparam logic [1:0] ST_SNOOZED = 2'd2;

    // per-channel configuration
    logic [4:0]      hour_q     [NUM_ALARMS];
    logic [4:0]      hour_d     [NUM_ALARMS];
    logic [5:0]      min_q      [NUM_ALARMS];
    logic [5:0]      min_d      [NUM_ALARMS];
    logic [5:0]      sec_q      [NUM_ALARMS];
    logic [5:0]      sec_d      [NUM_ALARMS];
    logic            en_q       [NUM_ALARMS];
    logic            en_d       [NUM_ALARMS];

    // per-channel FSM state and counters
    logic [1:0]      state_q    [NUM_ALARMS];
    logic [1:0]      state_d    [NUM_ALARMS];
    logic [7:0]      ring_cnt_q [NUM_ALARMS];
    logic [7:0]      ring_cnt_d [NUM_ALARMS];
    logic [11:0]     snz_cnt_q  [NUM_ALARMS];
    logic [11:0]     snz_cnt_d  [NUM_ALARMS];
    logic [SU_W-1:0] snz_used_q [NUM_ALARMS];
    logic [SU_W-1:0] snz_used_d [NUM_ALARMS];

    // registered outputs, all loaded from the next-state ringing vector
    logic [NUM_ALARMS-1:0] ring_d;
    logic [NUM_ALARMS-1:0] ring_vec_q;
    logic                  alarm_out_q;
    logic [IDX_W-1:0]      active_idx_d;
    logic [IDX_W-1:0]      active_idx_q;
    logic [2*NUM_ALARMS-1:0] state_dbg;

    // Next-state logic for every channel. Precedence, highest first:
    // config write to this channel, stop, snooze, one-second events.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            hour_d[i]     = hour_q[i];
            min_d[i]      = min_q[i];
            sec_d[i]      = sec_q[i];
            en_d[i]       = en_q[i];
            state_d[i]    = state_q[i];
            ring_cnt_d[i] = ring_cnt_q[i];
            snz_cnt_d[i]  = snz_cnt_q[i];
            snz_used_d[i] = snz_used_q[i];

            // An out-of-range cfg_idx equals no channel number, so it is
            // dropped without any separate range check.
            if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))) begin
                hour_d[i]     = bus.cfg_hour;
                min_d[i]      = bus.cfg_min;
                sec_d[i]      = bus.cfg_sec;
                en_d[i]       = bus.cfg_en;
                state_d[i]    = ST_IDLE;
                ring_cnt_d[i] = '0;
                snz_cnt_d[i]  = '0;
                snz_used_d[i] = '0;
            end else if (bus.stop) begin
                // Stop also masks this cycle's tick, so a channel cannot
                // start ringing on the same edge that stop is pressed.
                state_d[i] = ST_IDLE;
            end else if (bus.snooze && (state_q[i] == ST_RINGING)) begin
                if (snz_used_q[i] < SNZ_MAX) begin
                    state_d[i]    = ST_SNOOZED;
                    snz_cnt_d[i]  = '0;
                    snz_used_d[i] = snz_used_q[i] + 1'b1;
                end else begin
                    // out of snoozes: this press acts as stop
                    state_d[i] = ST_IDLE;
                end
            end else if (bus.sec_tick) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (en_q[i] &&
                            (hour_q[i] == bus.curr_hour) &&
                            (min_q[i]  == bus.curr_min) &&
                            (sec_q[i]  == bus.curr_sec)) begin
                            state_d[i]    = ST_RINGING;
                            ring_cnt_d[i] = '0;
                            snz_used_d[i] = '0;
                        end
                    end
                    ST_RINGING: begin
                        // the tick that brings the count to RING_SECS ends
                        // the ring, so the channel rings for RING_SECS ticks
                        if ((ring_cnt_q[i] + 8'd1) == RING_LAST) begin
                            state_d[i]    = ST_IDLE;
                            ring_cnt_d[i] = '0;
                        end else begin
                            ring_cnt_d[i] = ring_cnt_q[i] + 8'd1;
                        end
                    end
                    ST_SNOOZED: begin
                        if ((snz_cnt_q[i] + 12'd1) == SNZ_LAST) begin
                            state_d[i]    = ST_RINGING;
                            ring_cnt_d[i] = '0;
                            snz_cnt_d[i]  = '0;
                        end else begin
                            snz_cnt_d[i] = snz_cnt_q[i] + 12'd1;
                        end
                    end
                    default: begin
                        // unused encoding recovers to idle
                        state_d[i] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Next-state ringing vector and the lowest-index ringing channel
    always_comb begin
        ring_d       = '0;
        active_idx_d = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            ring_d[i] = (state_d[i] == ST_RINGING);
        end
        // walk downward so the lowest ringing index is the one that remains
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ring_d[i]) begin
                active_idx_d = IDX_W'(i);
            end
        end
    end

    // Channel state, configuration and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                hour_q[i]     <= '0;
                min_q[i]      <= '0;
                sec_q[i]      <= '0;
                en_q[i]       <= 1'b0;
                state_q[i]    <= ST_IDLE;
                ring_cnt_q[i] <= '0;
                snz_cnt_q[i]  <= '0;
                snz_used_q[i] <= '0;
            end
            ring_vec_q   <= '0;
            alarm_out_q  <= 1'b0;
            active_idx_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                hour_q[i]     <= hour_d[i];
                min_q[i]      <= min_d[i];
                sec_q[i]      <= sec_d[i];
                en_q[i]       <= en_d[i];
                state_q[i]    <= state_d[i];
                ring_cnt_q[i] <= ring_cnt_d[i];
                snz_cnt_q[i]  <= snz_cnt_d[i];
                snz_used_q[i] <= snz_used_d[i];
            end
            ring_vec_q   <= ring_d;
            alarm_out_q  <= |ring_d;
            active_idx_q <= active_idx_d;
        end
    end

    // Flatten per-channel state for the debug port
    always_comb begin
        state_dbg = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            state_dbg[2*i +: 2] = state_q[i];
        end
    end

    assign bus.ring_vec   = ring_vec_q;
    assign bus.alarm_out  = alarm_out_q;
    assign bus.active_idx = active_idx_q;
    assign bus.state_dbg  = state_dbg;
endmodule

// File: tb/tb_alarm_bank.sv
// Testbench for alarm_bank: directed scenarios followed by a randomized phase,
// with every cycle's outputs compared against a countdown-based model.
module tb_alarm_bank;
    localparam int NA = 4;
    localparam int RS = 60;
    localparam int SS = 300;
    localparam int MS = 3;
    localparam int IW = 2;
    localparam int DAY = 86400;

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;

    alarm_bank_if #(.NUM_ALARMS(NA)) bus ();

    alarm_bank #(
        .NUM_ALARMS (NA),
        .RING_SECS  (RS),
        .SNOOZE_SECS(SS),
        .MAX_SNOOZE (MS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Each channel: a mode, ticks left in the current phase, snoozes left.
    int m_mode     [NA];
    int m_left     [NA];
    int m_snz_left [NA];
    int m_time     [NA];
    bit m_en       [NA];

    logic [NA-1:0] exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int t     = 0;

    function automatic void model_reset();
        for (int i = 0; i < NA; i++) begin
            m_mode[i] = M_IDLE;
            m_left[i] = 0;
            m_snz_left[i] = 0;
            m_time[i] = 0;
            m_en[i] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        int now;
        logic [NA-1:0] e;
        now = int'(bus.curr_hour) * 3600 + int'(bus.curr_min) * 60 + int'(bus.curr_sec);
        for (int i = 0; i < NA; i++) begin
            if (bus.cfg_we && int'(bus.cfg_idx) == i) begin
                m_time[i] = int'(bus.cfg_hour) * 3600 + int'(bus.cfg_min) * 60 + int'(bus.cfg_sec);
                m_en[i] = bus.cfg_en;
                m_mode[i] = M_IDLE;
            end else if (bus.stop) begin
                m_mode[i] = M_IDLE;
            end else if (bus.snooze && m_mode[i] == M_RING) begin
                if (m_snz_left[i] > 0) begin
                    m_mode[i] = M_SNZ;
                    m_left[i] = SS;
                    m_snz_left[i]--;
                end else begin
                    m_mode[i] = M_IDLE;
                end
            end else if (bus.sec_tick) begin
                if (m_mode[i] == M_IDLE) begin
                    if (m_en[i] && m_time[i] == now) begin
                        m_mode[i] = M_RING;
                        m_left[i] = RS;
                        m_snz_left[i] = MS;
                    end
                end else begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        if (m_mode[i] == M_RING) begin
                            m_mode[i] = M_IDLE;
                        end else begin
                            m_mode[i] = M_RING;
                            m_left[i] = RS;
                        end
                    end
                end
            end
        end
        for (int i = 0; i < NA; i++) e[i] = (m_mode[i] == M_RING);
        exp_q.push_back(e);
    endfunction

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        logic [NA-1:0] e;
        int lo;
        if (exp_q.size() == 0) begin
            check_val("exp_q_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        lo = 0;
        for (int i = NA - 1; i >= 0; i--) if (e[i]) lo = i;
        check_val("ring_vec", 32'(bus.ring_vec), 32'(e));
        check_val("alarm_out", 32'(bus.alarm_out), 32'(e != '0));
        check_val("active_idx", 32'(bus.active_idx), 32'(lo));
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_pulses();
        bus.sec_tick = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.snooze   = 1'b0;
        bus.stop     = 1'b0;
    endtask

    // one clock: model follows the edge, outputs checked just after it
    task automatic do_cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_outputs();
        @(negedge clk);
        clear_pulses();
    endtask

    task automatic set_curr(input int tt);
        bus.curr_hour = 5'(tt / 3600);
        bus.curr_min  = 6'((tt / 60) % 60);
        bus.curr_sec  = 6'(tt % 60);
    endtask

    task automatic set_cfg(input int idx, input int tt, input bit en);
        bus.cfg_idx  = IW'(idx);
        bus.cfg_hour = 5'(tt / 3600);
        bus.cfg_min  = 6'((tt / 60) % 60);
        bus.cfg_sec  = 6'(tt % 60);
        bus.cfg_en   = en;
        bus.cfg_we   = 1'b1;
    endtask

    task automatic write_cfg(input int idx, input int tt, input bit en);
        set_cfg(idx, tt, en);
        do_cycle();
    endtask

    // sec_tick at a given time of day, followed by one quiet cycle
    task automatic tick_at(input int tt);
        set_curr(tt);
        bus.sec_tick = 1'b1;
        do_cycle();
        do_cycle();
    endtask

    task automatic tick();
        t = (t + 1) % DAY;
        tick_at(t);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_snooze();
        bus.snooze = 1'b1;
        do_cycle();
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        do_cycle();
    endtask

    // ---------------- stimulus ----------------
    int old_t;

    initial begin
        clear_pulses();
        set_curr(0);
        bus.cfg_idx = '0; bus.cfg_hour = '0; bus.cfg_min = '0; bus.cfg_sec = '0; bus.cfg_en = 1'b0;
        model_reset();

        #2 reset = 1'b1;
        #1;
        check_val("rst_ring_vec", 32'(bus.ring_vec), 32'd0);
        check_val("rst_alarm_out", 32'(bus.alarm_out), 32'd0);
        check_val("rst_active_idx", 32'(bus.active_idx), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: ch0 at 07:30:00 rings for exactly RS ticks
        write_cfg(0, 7 * 3600 + 30 * 60, 1'b1);
        t = 7 * 3600 + 30 * 60 - 3;
        ticks(2);
        check_val("t1_before", 32'(bus.ring_vec), 32'h0);
        tick();
        check_val("t1_rise", 32'(bus.ring_vec), 32'h1);
        check_val("t1_alarm", 32'(bus.alarm_out), 32'h1);
        ticks(RS - 1);
        check_val("t1_hold", 32'(bus.ring_vec), 32'h1);
        tick();
        check_val("t1_clear", 32'(bus.ring_vec), 32'h0);
        check_val("t1_alarm_clr", 32'(bus.alarm_out), 32'h0);

        // 2: ch1 and ch2 at 00:00:05, stop at tick 10
        write_cfg(1, 5, 1'b1);
        write_cfg(2, 5, 1'b1);
        t = 0;
        ticks(10);
        check_val("t2_ring", 32'(bus.ring_vec), 32'h6);
        check_val("t2_active", 32'(bus.active_idx), 32'd1);
        pulse_stop();
        check_val("t2_stop", 32'(bus.ring_vec), 32'h0);
        check_val("t2_active_clr", 32'(bus.active_idx), 32'd0);

        // 3: snooze three times with re-ring, fourth snooze stops
        write_cfg(0, t + 1, 1'b1);
        tick();
        check_val("t3_ring", 32'(bus.ring_vec), 32'h1);
        for (int k = 0; k < MS; k++) begin
            pulse_snooze();
            check_val("t3_snoozed", 32'(bus.ring_vec), 32'h0);
            ticks(SS - 1);
            check_val("t3_snz_hold", 32'(bus.ring_vec), 32'h0);
            tick();
            check_val("t3_rering", 32'(bus.ring_vec), 32'h1);
        end
        pulse_snooze();
        check_val("t3_last_snz", 32'(bus.ring_vec), 32'h0);
        ticks(SS + 1);
        check_val("t3_idle", 32'(bus.ring_vec), 32'h0);

        // 4: snooze and stop together
        write_cfg(0, t + 1, 1'b1);
        tick();
        check_val("t4_ring", 32'(bus.ring_vec), 32'h1);
        bus.snooze = 1'b1;
        bus.stop = 1'b1;
        do_cycle();
        check_val("t4_stop", 32'(bus.ring_vec), 32'h0);
        ticks(SS + 1);
        check_val("t4_no_rering", 32'(bus.ring_vec), 32'h0);

        // 5: disabled channel, rewrite while ringing, write on match cycle
        write_cfg(3, t + 1, 1'b0);
        tick();
        check_val("t5_disabled", 32'(bus.ring_vec), 32'h0);
        write_cfg(3, t + 1, 1'b1);
        tick();
        check_val("t5_ring", 32'(bus.ring_vec), 32'h8);
        check_val("t5_active", 32'(bus.active_idx), 32'd3);
        write_cfg(3, t, 1'b1);
        check_val("t5_rewrite", 32'(bus.ring_vec), 32'h0);
        t = t + 1;
        set_cfg(3, t, 1'b1);
        set_curr(t);
        bus.sec_tick = 1'b1;
        do_cycle();
        do_cycle();
        check_val("t5_wr_on_match", 32'(bus.ring_vec), 32'h0);

        // 6: async reset in the middle of a snooze
        old_t = t + 1;
        write_cfg(0, old_t, 1'b1);
        tick();
        check_val("t6_ring", 32'(bus.ring_vec), 32'h1);
        pulse_snooze();
        ticks(5);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_val("t6_rst_ring", 32'(bus.ring_vec), 32'h0);
        check_val("t6_rst_alarm", 32'(bus.alarm_out), 32'h0);
        check_val("t6_rst_active", 32'(bus.active_idx), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        ticks(SS);
        tick_at(old_t);
        check_val("t6_no_match", 32'(bus.ring_vec), 32'h0);

        // randomized phase: small time window so matches are frequent
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 99) < 12)
                set_cfg(int'($urandom_range(0, NA - 1)), int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 6) bus.snooze = 1'b1;
            if ($urandom_range(0, 99) < 3) bus.stop = 1'b1;
            set_curr(int'($urandom_range(0, 7)));
            if ($urandom_range(0, 99) < 60) bus.sec_tick = 1'b1;
            do_cycle();
        end

        check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
